// File: rtl/c7becl_excp_pkg.sv
// Shared constants and exception-priority decode for the ECL exception commit controller.
package c7becl_excp_pkg;

    // Exception codes reported to the CSR block
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // Commit controller states
    localparam logic [0:0] ECL_ST_IDLE  = 1'b0;
    localparam logic [0:0] ECL_ST_FLUSH = 1'b1;

    typedef struct packed {
        logic        hit;
        logic [5:0]  code;
        logic [31:0] badv;
    } excp_t;

    // Fixed-priority pick of the highest exception source (interrupt first, ALE last)
    function automatic excp_t excp_decode(input logic        int_pend,
                                          input logic        adef,
                                          input logic        ine,
                                          input logic        sys,
                                          input logic        brk,
                                          input logic        ale,
                                          input logic [31:0] pc,
                                          input logic [31:0] memaddr);
        excp_t r;
        r.hit  = 1'b1;
        r.code = ECODE_INT;
        r.badv = '0;
        if (int_pend) begin
            r.code = ECODE_INT;
        end else if (adef) begin
            r.code = ECODE_ADEF;
            r.badv = pc;
        end else if (ine) begin
            r.code = ECODE_INE;
        end else if (sys) begin
            r.code = ECODE_SYS;
        end else if (brk) begin
            r.code = ECODE_BRK;
        end else if (ale) begin
            r.code = ECODE_ALE;
            r.badv = memaddr;
        end else begin
            r.hit  = 1'b0;
            r.code = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/c7becl_intr_sync.sv
// Multi-flop synchronizer for the asynchronous external interrupt level.
module c7becl_intr_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw level through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/c7becl_excp.sv
// Exception/interrupt commit controller at the _w stage: strobes except/ertn to the CSR block,
// redirects fetch, and kills younger instructions for a fixed window afterwards.
module c7becl_excp
    import c7becl_excp_pkg::*;
#(
    parameter int unsigned FLUSH_CYC   = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_valid_w,
    input  logic [31:0] ifu_exu_pc_w,
    input  logic        exu_ale_w,
    input  logic [31:0] exu_memaddr_w,
    input  logic        exu_ine_w,
    input  logic        exu_sys_w,
    input  logic        exu_brk_w,
    input  logic        ifu_adef_w,
    input  logic        exu_ertn_w,
    input  logic        csr_ecl_crmd_ie,
    input  logic        csr_ecl_timer_intr,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    input  logic        ext_intr,
    output logic        ext_intr_sync,
    output logic        exu_ifu_except,
    output logic [5:0]  ecl_csr_exccode_w,
    output logic [31:0] ecl_csr_badv_w,
    output logic        ecl_csr_ertn_w,
    output logic        ecl_ifu_redirect,
    output logic [31:0] ecl_ifu_target,
    output logic        ecl_kill_w
);

    localparam int unsigned CNT_W = $clog2(FLUSH_CYC + 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q;
    logic             int_pend;
    logic             out_en;
    logic             active;
    logic             take_exc;
    logic             take_ertn;
    excp_t            dec;

    c7becl_intr_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_intr_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(ext_intr),
        .sync_out(ext_intr_sync)
    );

    // Exception selection and strobe qualification
    always_comb begin
        int_pend  = csr_ecl_crmd_ie & (csr_ecl_timer_intr | ext_intr_sync);
        dec       = excp_decode(int_pend, ifu_adef_w, exu_ine_w, exu_sys_w, exu_brk_w,
                                exu_ale_w, ifu_exu_pc_w, exu_memaddr_w);
        // Outputs stay quiet during reset and for the first cycle after it
        out_en    = armed_q & ~rst;
        active    = out_en & (state_q == ECL_ST_IDLE) & exu_valid_w;
        take_exc  = active & dec.hit;
        take_ertn = active & exu_ertn_w & ~dec.hit;
    end

    // Output drive; data buses are zero whenever no strobe fires
    always_comb begin
        exu_ifu_except    = take_exc;
        ecl_csr_ertn_w    = take_ertn;
        ecl_ifu_redirect  = take_exc | take_ertn;
        ecl_csr_exccode_w = take_exc ? dec.code : 6'h00;
        ecl_csr_badv_w    = take_exc ? dec.badv : 32'h0;
        ecl_ifu_target    = take_exc ? csr_eentry : (take_ertn ? csr_era : 32'h0);
        ecl_kill_w        = take_exc | (out_en & (state_q == ECL_ST_FLUSH));
    end

    // Next-state: enter FLUSH on any redirect, leave after FLUSH_CYC cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ECL_ST_IDLE) begin
            if (take_exc | take_ertn) begin
                state_d = ECL_ST_FLUSH;
                cnt_d   = CNT_W'(FLUSH_CYC);
            end
        end else begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = ECL_ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q - CNT_W'(1);
            end
        end
    end

    // State, counter and post-reset arm flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ECL_ST_IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_c7becl_excp.sv
// Directed self-checking bench for c7becl_excp (FLUSH_CYC=3, SYNC_STAGES=2).
module tb_c7becl_excp;

    localparam logic [31:0] EENTRY = 32'h1c00_8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid_w;
    logic [31:0] ifu_exu_pc_w;
    logic        exu_ale_w;
    logic [31:0] exu_memaddr_w;
    logic        exu_ine_w;
    logic        exu_sys_w;
    logic        exu_brk_w;
    logic        ifu_adef_w;
    logic        exu_ertn_w;
    logic        csr_ecl_crmd_ie;
    logic        csr_ecl_timer_intr;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        ext_intr;
    logic        ext_intr_sync;
    logic        exu_ifu_except;
    logic [5:0]  ecl_csr_exccode_w;
    logic [31:0] ecl_csr_badv_w;
    logic        ecl_csr_ertn_w;
    logic        ecl_ifu_redirect;
    logic [31:0] ecl_ifu_target;
    logic        ecl_kill_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    c7becl_excp #(
        .FLUSH_CYC  (3),
        .SYNC_STAGES(2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .exu_valid_w       (exu_valid_w),
        .ifu_exu_pc_w      (ifu_exu_pc_w),
        .exu_ale_w         (exu_ale_w),
        .exu_memaddr_w     (exu_memaddr_w),
        .exu_ine_w         (exu_ine_w),
        .exu_sys_w         (exu_sys_w),
        .exu_brk_w         (exu_brk_w),
        .ifu_adef_w        (ifu_adef_w),
        .exu_ertn_w        (exu_ertn_w),
        .csr_ecl_crmd_ie   (csr_ecl_crmd_ie),
        .csr_ecl_timer_intr(csr_ecl_timer_intr),
        .csr_eentry        (csr_eentry),
        .csr_era           (csr_era),
        .ext_intr          (ext_intr),
        .ext_intr_sync     (ext_intr_sync),
        .exu_ifu_except    (exu_ifu_except),
        .ecl_csr_exccode_w (ecl_csr_exccode_w),
        .ecl_csr_badv_w    (ecl_csr_badv_w),
        .ecl_csr_ertn_w    (ecl_csr_ertn_w),
        .ecl_ifu_redirect  (ecl_ifu_redirect),
        .ecl_ifu_target    (ecl_ifu_target),
        .ecl_kill_w        (ecl_kill_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Compare every strobe-side output against one expected vector
    task automatic chk_out(input string tag, input logic exc, input logic [5:0] code,
                           input logic [31:0] badv, input logic ertn, input logic redir,
                           input logic [31:0] tgt, input logic kill);
        #1;
        check({tag, ".except"},  {31'h0, exu_ifu_except},   {31'h0, exc});
        check({tag, ".exccode"}, {26'h0, ecl_csr_exccode_w}, {26'h0, code});
        check({tag, ".badv"},    ecl_csr_badv_w,             badv);
        check({tag, ".ertn"},    {31'h0, ecl_csr_ertn_w},    {31'h0, ertn});
        check({tag, ".redir"},   {31'h0, ecl_ifu_redirect},  {31'h0, redir});
        check({tag, ".target"},  ecl_ifu_target,             tgt);
        check({tag, ".kill"},    {31'h0, ecl_kill_w},        {31'h0, kill});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        exu_valid_w = 0; exu_ale_w = 0; exu_ine_w = 0; exu_sys_w = 0; exu_brk_w = 0;
        ifu_adef_w = 0; exu_ertn_w = 0; ifu_exu_pc_w = '0; exu_memaddr_w = '0;
    endtask

    // Three kill-only cycles with current inputs held, then idle with inputs cleared
    task automatic flush_window(input string tag);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_out($sformatf("%s.flush%0d", tag, i), 0, 6'h00, 32'h0, 0, 0, 32'h0, 1);
        end
        cyc();
        clear_in();
        chk_out({tag, ".after"}, 0, 6'h00, 32'h0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        clear_in();
        rst = 1; csr_ecl_crmd_ie = 0; csr_ecl_timer_intr = 0; ext_intr = 0;
        csr_eentry = EENTRY; csr_era = 32'h0;

        // Reset held with an ALE presented: everything quiet
        exu_valid_w = 1; exu_ale_w = 1; exu_memaddr_w = 32'h0000_0001;
        chk_out("rst_hold", 0, 6'h00, 32'h0, 0, 0, 32'h0, 0);
        check("rst_hold.sync", {31'h0, ext_intr_sync}, 32'h0);
        cyc();
        rst = 0;
        chk_out("rst_first", 0, 6'h00, 32'h0, 0, 0, 32'h0, 0);
        cyc();
        clear_in();
        chk_out("idle_noflag", 0, 6'h00, 32'h0, 0, 0, 32'h0, 0);

        // ALE taken, then further ALEs ignored in the window
        exu_valid_w = 1; exu_ale_w = 1; exu_memaddr_w = 32'h0000_1003;
        ifu_exu_pc_w = 32'h1c00_0040;
        chk_out("ale", 1, 6'h09, 32'h0000_1003, 0, 1, EENTRY, 1);
        flush_window("ale");

        // Reset mid-FLUSH, then a normal ALE
        exu_valid_w = 1; exu_ale_w = 1; exu_memaddr_w = 32'h0000_2002;
        ifu_exu_pc_w = 32'h1c00_0010;
        chk_out("pre_rst", 1, 6'h09, 32'h0000_2002, 0, 1, EENTRY, 1);
        cyc();
        chk_out("pre_rst.flush", 0, 6'h00, 32'h0, 0, 0, 32'h0, 1);
        rst = 1;
        chk_out("mid_rst", 0, 6'h00, 32'h0, 0, 0, 32'h0, 0);
        cyc();
        rst = 0;
        chk_out("mid_rst.first", 0, 6'h00, 32'h0, 0, 0, 32'h0, 0);
        cyc();
        chk_out("post_rst_ale", 1, 6'h09, 32'h0000_2002, 0, 1, EENTRY, 1);
        flush_window("post_rst_ale");

        // Priority among synchronous sources
        exu_valid_w = 1; exu_ine_w = 1; exu_sys_w = 1; ifu_exu_pc_w = 32'h1c00_0050;
        chk_out("ine_sys", 1, 6'h0D, 32'h0, 0, 1, EENTRY, 1);
        flush_window("ine_sys");
        exu_valid_w = 1; exu_ine_w = 1; exu_sys_w = 1; ifu_adef_w = 1;
        ifu_exu_pc_w = 32'h1c00_0050;
        chk_out("adef", 1, 6'h08, 32'h1c00_0050, 0, 1, EENTRY, 1);
        flush_window("adef");
        exu_valid_w = 1; exu_sys_w = 1; exu_brk_w = 1; exu_ale_w = 1;
        chk_out("sys", 1, 6'h0B, 32'h0, 0, 1, EENTRY, 1);
        flush_window("sys");
        exu_valid_w = 1; exu_brk_w = 1; exu_ale_w = 1; exu_memaddr_w = 32'h0000_0007;
        chk_out("brk", 1, 6'h0C, 32'h0, 0, 1, EENTRY, 1);
        flush_window("brk");

        // External interrupt: synchronizer latency, then taken once
        csr_ecl_crmd_ie = 1; ext_intr = 1;
        #1 check("sync.c0", {31'h0, ext_intr_sync}, 32'h0);
        cyc();
        check("sync.c1", {31'h0, ext_intr_sync}, 32'h0);
        chk_out("ext_novalid", 0, 6'h00, 32'h0, 0, 0, 32'h0, 0);
        cyc();
        check("sync.c2", {31'h0, ext_intr_sync}, 32'h1);
        chk_out("ext_novalid2", 0, 6'h00, 32'h0, 0, 0, 32'h0, 0);
        exu_valid_w = 1; ifu_exu_pc_w = 32'h1c00_0080;
        chk_out("ext_int", 1, 6'h00, 32'h0, 0, 1, EENTRY, 1);
        flush_window("ext_int");
        csr_ecl_crmd_ie = 0; ext_intr = 0;
        cyc(); cyc();
        check("sync.fall", {31'h0, ext_intr_sync}, 32'h0);

        // Masked timer interrupt, then ertn
        csr_ecl_timer_intr = 1;
        for (int i = 0; i < 3; i++) begin
            exu_valid_w = 1; ifu_exu_pc_w = 32'h1c00_0090 + 32'(4 * i);
            chk_out($sformatf("masked%0d", i), 0, 6'h00, 32'h0, 0, 0, 32'h0, 0);
            cyc();
        end
        csr_era = 32'h1c00_0100; exu_ertn_w = 1;
        chk_out("ertn", 0, 6'h00, 32'h0, 1, 1, 32'h1c00_0100, 0);
        flush_window("ertn");

        // Interrupt on an ertn: exception wins
        csr_ecl_crmd_ie = 1; exu_valid_w = 1; exu_ertn_w = 1;
        chk_out("int_ertn", 1, 6'h00, 32'h0, 0, 1, EENTRY, 1);
        flush_window("int_ertn");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
